// File: rtl/jk_pkg.sv
// Shared encodings for the JK bank sequencer: per-cell {j,k} op codes and FSM states.
package jk_pkg;
  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/jk_bank_sequencer_if.sv
// Command channel between a control master and the JK bank sequencer (valid/ready).
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;

  modport master (output cmd_valid, cmd_op, cmd_mask, cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_mask, cmd_count, output cmd_ready);
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to q=0; q_bar is always ~q.
module jk_cell
  import jk_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        OP_HOLD:  q <= q;
        OP_CLEAR: q <= 1'b0;
        OP_SET:   q <= 1'b1;
        default:  q <= ~q;
      endcase
    end
  end

  assign q_bar = ~q;
endmodule

// File: rtl/jk_bank_sequencer.sv
// Applies one latched JK op to a masked bank of cells for count+1 edges, then pulses done.
// Optional abort input (early exit from RUN) is enabled by defining JK_BANK_ABORT_EN.
module jk_bank_sequencer
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
)(
  input  logic             clock,
  input  logic             reset,
  jk_bank_sequencer_if.slave cmd,
`ifdef JK_BANK_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);
  state_t           state, state_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic             accept;
  logic             run_last;

  assign accept = cmd.cmd_valid && (state == ST_IDLE);

`ifdef JK_BANK_ABORT_EN
  assign run_last = (remaining == '0) || abort;
`else
  assign run_last = (remaining == '0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)   state_nxt = ST_RUN;
      ST_RUN:  if (run_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // remaining counts down from cmd_count, so count = 2^CNT_W-1 never wraps
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_r      <= OP_HOLD;
      mask_r    <= '0;
      remaining <= '0;
    end else if (accept) begin
      op_r      <= cmd.cmd_op;
      mask_r    <= cmd.cmd_mask;
      remaining <= cmd.cmd_count;
    end else if (state == ST_RUN && remaining != '0) begin
      remaining <= remaining - 1'b1;
    end
  end

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (state == ST_RUN) begin
      j_vec = mask_r & {WIDTH{op_r[1]}};
      k_vec = mask_r & {WIDTH{op_r[0]}};
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clock (clock),
      .reset (reset),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven sequencer for a bank of JK flip-flop cells. Accepts one command at a time over a valid/ready handshake and applies the command's JK operation (hold, clear, set, toggle) to a masked subset of the bank for a programmed number of consecutive clock edges. It then signals completion. It sits between a control master and the JK register bank, and is the only driver of every cell's j/k inputs.

## Interface
Parameters:
- WIDTH, 8, number of JK cells in the bank
- CNT_W, 4, width of the repeat-count field

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  JK operation as {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
- cmd_mask  in  WIDTH  1 = cell participates; 0 = cell receives {j,k}=00
- cmd_count  in  CNT_W  number of applications minus one
- busy  out  1  command in progress (RUN or DONE)
- done  out  1  one-cycle completion pulse
- q  out  WIDTH  cell outputs
- q_bar  out  WIDTH  complementary cell outputs; always equals ~q
- abort  in  1  present only with JK_BANK_ABORT_EN

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid & cmd_ready, latch op, mask and remaining=cmd_count, then go to RUN.
- RUN:
  - Every masked cell gets {j,k}=op; unmasked cells get 00.
  - The cells update on the rising edge that ends each RUN cycle.
  - If remaining==0, go to DONE; otherwise decrement remaining.
  - RUN lasts exactly cmd_count+1 cycles.
- DONE:
  - done=1 for exactly one cycle, all j/k=00, then go to IDLE.
- Per-cell behaviour:
  - 00 holds q.
  - 01 gives q=0.
  - 10 gives q=1.
  - 11 gives q=~q.
  - q_bar tracks ~q in all cases.
- cmd_ready is 0 in RUN and DONE. cmd_valid in those states is ignored; the producer holds the command.
- cmd_op=00 or cmd_mask=0 is legal. The command still occupies count+1 RUN cycles, q is unchanged, and done pulses.
- Width rules:
  - remaining is CNT_W bits.
  - cmd_count = 2^CNT_W−1 gives 2^CNT_W applications, with no wrap.
- Reset (asynchronous, at any time including mid-RUN):
  - state=IDLE, remaining=0.
  - q=all 0, q_bar=all 1.
  - done=0, busy=0, cmd_ready=1 once reset deasserts.

## Timing
- Handshake cycle T (IDLE) → RUN cycles T+1 … T+1+count.
- The first q change is visible at T+2 and the last at T+2+count.
- done=1 in cycle T+2+count (DONE).
- cmd_ready returns to 1 at T+3+count. Minimum command period: count+3 cycles.
- Outputs q, q_bar, done, busy and cmd_ready are registered or derived from state only. There is no combinational path from cmd_* to outputs, except that cmd_ready depends on state alone.

## Configuration
- JK_BANK_ABORT_EN:
  - Defined: the abort port exists. abort=1 sampled in RUN forces the next state to DONE. The RUN cycle in which abort is sampled still applies op, then done pulses normally. abort in IDLE or DONE has no effect.
  - Undefined: no abort port, and RUN always completes count+1 applications.

## Structure
- Package jk_pkg holds:
  - Op encoding constants OP_HOLD=2'b00, OP_CLEAR=2'b01, OP_SET=2'b10, OP_TOGGLE=2'b11.
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE.
- Sub-module jk_cell:
  - One flip-flop per bank bit, instantiated WIDTH times via generate.
  - Ports clock, reset, j, k, q, q_bar.
  - Asynchronous active-high reset to q=0, q_bar=1; JK truth table on the rising edge.
- The sequencer FSM, counter and mask/op registers live in the top module.

## Test plan
- Reset, then cmd op=10, mask=8'h0F, count=0 → q=8'h0F at T+2; done pulses at T+2; cmd_ready=1 at T+3.
- From q=8'h00, op=11, mask=8'hFF, count=2 → q toggles to FF, 00, FF on three consecutive edges; final q=8'hFF; done one cycle; q_bar=8'h00.
- cmd_valid held high through RUN and DONE with a second command (op=01, mask=8'hF0) → second command accepted only in the IDLE cycle at T+3+count; final q=8'h0F.
- Assert reset mid-RUN of op=11, count=15 → immediate q=0, q_bar=FF, done=0, busy=0; no further toggles after reset release.
- op=10, mask=8'h00, count=3 → q unchanged for 4 RUN cycles; done at T+5.
- (JK_BANK_ABORT_EN) op=11, mask=8'h01, count=9, abort=1 in the third RUN cycle → exactly 3 toggles (q[0]=1); done in the next cycle.
